dnn_result_stream: RTL and testbench

DNN_RESULT_STREAM -- requirements
Module: dnn_result_stream

---
 rtl/dnn_result_stream.sv | 203 ++++++++++++++++++++
 tb/tb_dnn_result_stream.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dnn_result_stream.sv
// rtl/dnn_result_stream.sv - capture parallel core sums, quantise into a result buffer, stream it out
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 opens a sample (IDLE -> COLLECT, clears ovf_err)
//   fin                   closes collection; drain begins once the serialiser is idle
//   cap, cap_sum,         capture F_NUM channel sums plus their write base and
//   cap_base, relu, shift quantisation settings
//   ds                    words streamed per sample (0 = no stream)
//   busy                  serialiser is writing captured channels to the buffer
//   ovf_err               sticky: a capture was dropped
//   dst_valid, dst_data,  result stream, words 0..ds-1 of the buffer
//   dst_last, dst_ready
module dnn_result_stream #(
    parameter int F_NUM = 16,
    parameter int DW    = 32,
    parameter int OW    = 16,
    parameter int AW    = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                fin,
    input  logic                cap,
    input  logic [F_NUM*DW-1:0] cap_sum,
    input  logic [AW-1:0]       cap_base,
    input  logic                relu,
    input  logic [4:0]          shift,
    input  logic [AW-1:0]       ds,
    output logic                busy,
    output logic                ovf_err,
    output logic                dst_valid,
    output logic [OW-1:0]       dst_data,
    output logic                dst_last,
    input  logic                dst_ready
);

    localparam int CW = (F_NUM > 1) ? $clog2(F_NUM) : 1;

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [F_NUM*DW-1:0] sum_q, sum_d;
    logic [AW-1:0]       base_q, base_d;
    logic                relu_q, relu_d;
    logic [4:0]          shift_q, shift_d;
    logic                fin_pend_q, fin_pend_d;
    logic                ovf_q, ovf_d;
    logic [AW-1:0]       ds_q, ds_d;
    logic [AW-1:0]       rd_q, rd_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic [OW-1:0]       data_q, data_d;

    logic [OW-1:0] mem [0:(1<<AW)-1];

    // Serialiser is on its final channel; a capture here chains straight on.
    logic busy_last;
    logic cap_ok;
    assign busy_last = busy_q && (cnt_q == CW'(F_NUM - 1));
    assign cap_ok    = cap && (state_q == S_COLLECT) && (!busy_q || busy_last);

    // Quantise the channel currently being serialised.
    logic        [DW-1:0] ch_sum;
    logic signed [DW-1:0] shifted;
    logic signed [DW-1:0] clamped;
    logic                 fits;
    logic        [OW-1:0] wr_word;
    logic        [AW-1:0] wr_addr;

    assign ch_sum  = sum_q[cnt_q*DW +: DW];
    assign shifted = $signed(ch_sum) >>> shift_q;
    assign clamped = (relu_q && shifted[DW-1]) ? '0 : shifted;
    // Value fits in OW bits when every bit above the output sign bit matches it.
    assign fits    = (&clamped[DW-1:OW-1]) || !(|clamped[DW-1:OW-1]);
    assign wr_word = fits          ? clamped[OW-1:0] :
                     clamped[DW-1] ? {1'b1, {(OW-1){1'b0}}} :
                                     {1'b0, {(OW-1){1'b1}}};
    assign wr_addr = base_q + AW'(cnt_q);

    always_ff @(posedge clk) begin
        if (busy_q) begin
            mem[wr_addr] <= wr_word;
        end
    end

    // A new word is presented on drain entry and after every handshake but the last.
    logic load;
    assign load = (state_q == S_DRAIN) && (!valid_q || (dst_ready && !last_q));

    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        base_d     = base_q;
        relu_d     = relu_q;
        shift_d    = shift_q;
        fin_pend_d = fin_pend_q;
        ovf_d      = ovf_q;
        ds_d       = ds_q;
        rd_d       = rd_q;
        valid_d    = valid_q;
        last_d     = last_q;
        data_d     = data_q;

        if (cap_ok) begin
            sum_d   = cap_sum;
            base_d  = cap_base;
            relu_d  = relu;
            shift_d = shift;
            busy_d  = 1'b1;
            cnt_d   = '0;
        end else if (busy_q) begin
            if (busy_last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        if (cap && !cap_ok) begin
            ovf_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                fin_pend_d = 1'b0;
                if (start) begin
                    state_d = S_COLLECT;
                    ovf_d   = 1'b0;
                end
            end
            S_COLLECT: begin
                if ((fin || fin_pend_q) && !busy_q && !cap_ok) begin
                    fin_pend_d = 1'b0;
                    ds_d       = ds;
                    rd_d       = '0;
                    state_d    = (ds == '0) ? S_IDLE : S_DRAIN;
                end else if (fin) begin
                    fin_pend_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (load) begin
                    valid_d = 1'b1;
                    data_d  = mem[rd_q];
                    last_d  = (rd_q == ds_q - AW'(1));
                    rd_d    = rd_q + AW'(1);
                end else if (dst_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            sum_q      <= '0;
            base_q     <= '0;
            relu_q     <= 1'b0;
            shift_q    <= '0;
            fin_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            ds_q       <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            base_q     <= base_d;
            relu_q     <= relu_d;
            shift_q    <= shift_d;
            fin_pend_q <= fin_pend_d;
            ovf_q      <= ovf_d;
            ds_q       <= ds_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            data_q     <= data_d;
        end
    end

    assign busy      = busy_q;
    assign ovf_err   = ovf_q;
    assign dst_valid = valid_q;
    assign dst_data  = data_q;
    assign dst_last  = last_q;

endmodule

// File: tb/tb_dnn_result_stream.sv
// tb/tb_dnn_result_stream.sv - self-checking bench for dnn_result_stream
module tb_dnn_result_stream;

    localparam int F_NUM = 16;
    localparam int DW    = 32;
    localparam int OW    = 16;
    localparam int AW    = 12;
    localparam longint MAXV = (longint'(1) << (OW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (OW - 1));

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic                start = 1'b0;
    logic                fin = 1'b0;
    logic                cap = 1'b0;
    logic [F_NUM*DW-1:0] cap_sum = '0;
    logic [AW-1:0]       cap_base = '0;
    logic                relu = 1'b0;
    logic [4:0]          shift = '0;
    logic [AW-1:0]       ds = '0;
    logic                busy;
    logic                ovf_err;
    logic                dst_valid;
    logic [OW-1:0]       dst_data;
    logic                dst_last;
    logic                dst_ready = 1'b0;

    dnn_result_stream #(.F_NUM(F_NUM), .DW(DW), .OW(OW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .fin      (fin),
        .cap      (cap),
        .cap_sum  (cap_sum),
        .cap_base (cap_base),
        .relu     (relu),
        .shift    (shift),
        .ds       (ds),
        .busy     (busy),
        .ovf_err  (ovf_err),
        .dst_valid(dst_valid),
        .dst_data (dst_data),
        .dst_last (dst_last),
        .dst_ready(dst_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [OW-1:0] smem [0:(1<<AW)-1];
    logic [OW:0]   sbq [$];

    int   popped = 0;
    int   valid_cycles = 0;
    int   busy_run = 0;
    int   last_busy_run = 0;
    logic stall_q = 1'b0;
    logic [OW-1:0] st_data = '0;
    logic st_last = 1'b0;

    bit       rdy_mode = 1'b0;
    logic [3:0] pat = 4'b1001;

    typedef struct {
        logic [DW-1:0] sum;
        logic [4:0]    sh;
        logic          r;
        logic [OW-1:0] exp;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] conv_model(input logic [DW-1:0] s, input logic [4:0] sh,
                                                 input logic r);
        longint t;
        t = longint'($signed(s)) >>> sh;
        if (r && t < 0) t = 0;
        if (t > MAXV) t = MAXV;
        if (t < MINV) t = MINV;
        return t[OW-1:0];
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_cap(input logic [F_NUM*DW-1:0] sums, input logic [AW-1:0] base,
                          input logic [4:0] sh, input logic r, input bit accepted,
                          input bit use_tbl, input logic [OW-1:0] texp);
        cap = 1'b1; cap_sum = sums; cap_base = base; shift = sh; relu = r;
        if (accepted) begin
            for (int i = 0; i < F_NUM; i++) begin
                smem[AW'(int'(base) + i)] = use_tbl ? texp : conv_model(sums[i*DW +: DW], sh, r);
            end
        end
        @(posedge clk); #1;
        cap = 1'b0;
    endtask

    task automatic do_fin(input int n);
        ds = AW'(n);
        for (int i = 0; i < n; i++) sbq.push_back({(i == n - 1), smem[i]});
        fin = 1'b1;
        @(posedge clk); #1;
        fin = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (sbq.size() == 0 && !dst_valid && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1);
    endtask

    task automatic wait_not_busy(input string nm);
        bit ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk(nm, ok, 1);
        @(negedge clk); #1;
    endtask

    // Output monitor / scoreboard consumer
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_q = 1'b0;
        end else begin
            if (dst_valid) valid_cycles++;
            if (stall_q && dst_valid) begin
                chk("stall_data", dst_data, st_data);
                chk("stall_last", dst_last, st_last);
            end
            if (dst_valid && dst_ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_word: got %0h expected none", dst_data);
                end else begin
                    logic [OW:0] e;
                    e = sbq.pop_front();
                    chk("word_data", dst_data, e[OW-1:0]);
                    chk("word_last", dst_last, e[OW]);
                    popped++;
                end
            end
            stall_q = dst_valid && !dst_ready;
            st_data = dst_data;
            st_last = dst_last;
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                last_busy_run = busy_run;
                busy_run = 0;
            end
        end
    end

    // Sink ready driver
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode) begin
                dst_ready = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                dst_ready = 1'b1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [F_NUM*DW-1:0] sums;
        int v0;
        int p0;
        bit ok;

        tbl[0]  = '{32'hFFFE_EE90, 5'd0,  1'b0, 16'h8000};
        tbl[1]  = '{32'hFFFE_EE90, 5'd0,  1'b1, 16'h0000};
        tbl[2]  = '{32'h7FFF_FFFF, 5'd0,  1'b0, 16'h7FFF};
        tbl[3]  = '{32'hFFFF_FB00, 5'd8,  1'b0, 16'hFFFB};
        tbl[4]  = '{32'hFFFF_FFFF, 5'd4,  1'b0, 16'hFFFF};
        tbl[5]  = '{32'h0001_2345, 5'd4,  1'b0, 16'h1234};
        tbl[6]  = '{32'hFFFF_F448, 5'd2,  1'b1, 16'h0000};
        tbl[7]  = '{32'h8000_0000, 5'd31, 1'b0, 16'hFFFF};
        tbl[8]  = '{32'h7FFF_0000, 5'd16, 1'b0, 16'h7FFF};
        tbl[9]  = '{32'hFFFE_0000, 5'd2,  1'b0, 16'h8000};
        tbl[10] = '{32'h0010_0000, 5'd4,  1'b0, 16'h7FFF};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_valid", dst_valid, 0);
        chk("rst_last", dst_last, 0);
        chk("rst_data", dst_data, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic sample: ch i = i<<8, shift 8 -> words 0..15
        do_start();
        for (int i = 0; i < F_NUM; i++) sums[i*DW +: DW] = DW'(i << 8);
        do_cap(sums, '0, 5'd8, 1'b0, 1'b1, 1'b0, '0);
        wait_not_busy("basic_busy_drop");
        chk("basic_busy_len", last_busy_run, F_NUM);
        v0 = valid_cycles;
        do_fin(16);
        wait_done("basic_done");
        chk("basic_valid_cycles", valid_cycles - v0, 16);

        // Conversion table
        for (int k = 0; k < 11; k++) begin
            do_start();
            do_cap({F_NUM{tbl[k].sum}}, '0, tbl[k].sh, tbl[k].r, 1'b1, 1'b1, tbl[k].exp);
            do_fin(2);
            wait_done("tbl_done");
        end

        // Address wrap at base 4090
        do_start();
        for (int i = 0; i < F_NUM; i++) sums[i*DW +: DW] = DW'((i + 100) << 8);
        do_cap(sums, AW'(4090), 5'd8, 1'b0, 1'b1, 1'b0, '0);
        do_fin(10);
        wait_done("wrap_done");

        // Dropped capture 3 cycles after the first
        do_start();
        for (int i = 0; i < F_NUM; i++) sums[i*DW +: DW] = DW'(i * 1000);
        do_cap(sums, '0, 5'd0, 1'b0, 1'b1, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < F_NUM; i++) sums[i*DW +: DW] = DW'(12345 + i);
        do_cap(sums, '0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
        chk("ovf_set", ovf_err, 1);
        wait_not_busy("ovf_busy_drop");
        do_fin(16);
        wait_done("ovf_done");
        chk("ovf_held", ovf_err, 1);
        do_start();
        chk("ovf_cleared", ovf_err, 0);

        // Capture on the busy-fall cycle chains straight on
        for (int i = 0; i < F_NUM; i++) sums[i*DW +: DW] = DW'(i * 7 - 50);
        do_cap(sums, '0, 5'd0, 1'b1, 1'b1, 1'b0, '0);
        repeat (15) @(posedge clk);
        #1;
        for (int i = 0; i < F_NUM; i++) sums[i*DW +: DW] = DW'(-(i * 300) - 1);
        do_cap(sums, AW'(16), 5'd1, 1'b0, 1'b1, 1'b0, '0);
        wait_not_busy("chain_busy_drop");
        chk("chain_busy_len", last_busy_run, 2 * F_NUM);
        chk("chain_no_ovf", ovf_err, 0);
        do_fin(32);
        wait_done("chain_done");

        // Backpressure with ready pattern 1,0,0,1
        do_start();
        rdy_mode = 1'b1;
        p0 = popped;
        do_fin(16);
        wait_done("bp_done");
        chk("bp_words", popped - p0, 16);
        rdy_mode = 1'b0;

        // ds = 0: back to IDLE without output
        do_start();
        v0 = valid_cycles;
        do_fin(0);
        repeat (20) @(posedge clk);
        #1;
        chk("ds0_no_valid", valid_cycles - v0, 0);
        chk("ds0_ovf_before", ovf_err, 0);
        do_cap(sums, '0, 5'd0, 1'b0, 1'b0, 1'b0, '0);
        chk("ds0_idle_cap_drop", ovf_err, 1);

        // Reset during drain at word 5
        do_start();
        p0 = popped;
        do_fin(16);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (popped - p0 == 5) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("rst5_reached", ok, 1);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("rst5_valid", dst_valid, 0);
        chk("rst5_last", dst_last, 0);
        chk("rst5_data", dst_data, 0);
        chk("rst5_ovf", ovf_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        v0 = valid_cycles;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_quiet", valid_cycles - v0, 0);
        chk("post_rst_busy", busy, 0);
        do_start();
        do_fin(3);
        wait_done("post_rst_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
